sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Merges the CPU's instruction-fetch and data-access SRAM-like master channels onto one shared SRAM-like slave port.
- The slave port feeds the bus bridge or cache.
- Grants one address-phase request per cycle.
- Records the requester of every accepted request in an in-order FIFO, so responses (data_ok/rdata) return to the correct master.
- Sits between the fetch/memory stages and the bus interface.

Parameters:
- OUTSTANDING, 4: max accepted-but-unanswered requests; power of two, ≥2.
- STARVE_MAX, 7: consecutive cycles inst may lose arbitration before it is forced to win once.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch response valid this cycle.
- inst_rdata  out  32  fetch response data.
- data_req  in  1  data request; held with its fields until data_addr_ok.
- data_wr  in  1  1 = write.
- data_size  in  2  0/1/2 = byte/half/word.
- data_addr  in  32  data address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data response valid (read data or write ack).
- data_rdata  out  32  read data.
- bus_req  out  1  slave request.
- bus_wr  out  1  slave write flag.
- bus_size  out  2  slave size.
- bus_addr  out  32  slave address.
- bus_wdata  out  32  slave write data.
- bus_addr_ok  in  1  slave accepted request.
- bus_data_ok  in  1  slave response valid.
- bus_rdata  in  32  slave read data.
- outstanding  out  clog2(OUTSTANDING)+1  number of in-flight requests.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO empty, outstanding=0, starve counter=0, err=0.
  - All *_ok outputs 0; bus_req 0.
  - rdata outputs are don't-care but driven from bus_rdata.
- Full: fifo_full = (outstanding == OUTSTANDING). Grant logic is combinational, same cycle.
- sel_data = data_req && !(inst_req && starve_cnt == STARVE_MAX).
  - sel_inst = inst_req && !sel_data.
  - Data has fixed priority except for the anti-starvation override.
- bus_req = (inst_req || data_req) && !fifo_full.
- Slave fields mux by sel_data:
  - inst path: wr=0, size=2, addr=inst_addr, wdata=0.
  - data path: all data_* fields.
- Address-ok routing:
  - inst_addr_ok = bus_addr_ok && bus_req && sel_inst.
  - data_addr_ok = bus_addr_ok && bus_req && sel_data.
  - No *_addr_ok when fifo_full.
- Acceptance: on bus_addr_ok && bus_req, push requester ID (0 = inst, 1 = data) to the FIFO tail.
- Starve counter:
  - Increments, saturating at STARVE_MAX, in a cycle where inst_req=1 and inst_addr_ok=0.
  - Clears on inst_addr_ok or when inst_req=0.
- Response routing:
  - On bus_data_ok with FIFO non-empty, pop head.
  - head=0 → inst_data_ok=1; head=1 → data_data_ok=1.
  - inst_rdata = data_rdata = bus_rdata, zero added latency.
  - Responses are strictly in acceptance order; the slave guarantees in-order return.
- Simultaneous push and pop: both take effect; outstanding unchanged.
  - A push is permitted while full only if a pop happens the same cycle? No: bus_req is blocked when full regardless, so there is no combinational path from bus_data_ok to bus_req.
- Wrap-around: pointers are clog2(OUTSTANDING) bits and wrap naturally; outstanding is tracked separately.
- bus_data_ok with FIFO empty: no *_data_ok asserted, FIFO unchanged, err←1 (sticky until reset).
- Request changes: a master dropping its req before addr_ok is permitted (e.g. fetch cancel); arbitration re-evaluates every cycle with no lock.
- Reset mid-operation: all in-flight tracking is discarded. The slave is reset by the same resetn, so no stale responses are expected.

Decomposition:
- Shared package/header (alongside common.vh):
  - requester ID constants REQ_INST=1'b0, REQ_DATA=1'b1.
  - SIZE_BYTE/HALF/WORD encodings.
- One sub-module: arb_id_fifo.
  - Parameterised depth, 1-bit width.
  - push/pop/full/empty/count/head.
  - Asynchronous active-low reset.

Test Plan:
- Single inst_req addr 0xBFC00000; slave gives addr_ok in cycle 0, data_ok+rdata 0x3C080001 in cycle 2:
  - inst_addr_ok in cycle 0.
  - inst_data_ok=1, inst_rdata=0x3C080001 in cycle 2.
  - data_data_ok stays 0.
- inst_req and data_req both held (data read 0x80001000), slave addr_ok every cycle:
  - data accepted first; inst accepted next cycle.
  - Responses D then I route to data_data_ok then inst_data_ok.
- Slave never asserts data_ok, both masters requesting:
  - exactly 4 acceptances, then bus_req=0, outstanding=4.
  - One bus_data_ok → outstanding 3, next request accepted the following cycle.
- data_req held continuously plus inst_req, slave always addr_ok:
  - inst loses 7 cycles (starve_cnt reaches 7), wins on the 8th.
  - Counter returns to 0.
- bus_data_ok pulse with empty FIFO:
  - err=1 and stays 1.
  - Neither *_data_ok asserts.
  - Only resetn low clears err.
- Assert resetn=0 asynchronously (between clock edges) with 3 outstanding:
  - outstanding=0, bus_req=0 immediately.
  - After release, a new inst request proceeds normally.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared constants for the instruction/data SRAM-bus arbiter: requester IDs
// recorded in the response-order FIFO and the SRAM-like size encodings.
package sram_bus_arbiter_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_id_fifo.sv
// 1-bit-wide in-order FIFO holding the requester ID of each accepted request
// until its response returns; count is kept apart from the wrapping pointers.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        id_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o,
  output logic        head_o
);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= id_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Merges the fetch and data SRAM-like masters onto one slave port: data wins
// by default, a starved fetch is forced through once, responses routed in order.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int STARVE_MAX  = 7,
  parameter int CW          = $clog2(OUTSTANDING) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [31:0]   inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [31:0]   bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [31:0]   bus_rdata,
  output logic [CW-1:0] outstanding,
  output logic          err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic          fifo_full, fifo_empty, fifo_head;
  logic          sel_data, sel_inst, accept, pop;

  assign sel_data = data_req && !(inst_req && (starve_q == SW'(STARVE_MAX)));
  assign sel_inst = inst_req && !sel_data;

  // Gated by resetn so nothing can be granted or pushed while reset is held.
  assign bus_req   = resetn && (inst_req || data_req) && !fifo_full;
  assign bus_wr    = sel_data ? data_wr    : 1'b0;
  assign bus_size  = sel_data ? data_size  : SIZE_WORD;
  assign bus_addr  = sel_data ? data_addr  : inst_addr;
  assign bus_wdata = sel_data ? data_wdata : 32'h0;

  assign accept       = bus_addr_ok && bus_req;
  assign inst_addr_ok = accept && sel_inst;
  assign data_addr_ok = accept && sel_data;

  assign pop          = bus_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (fifo_head == REQ_INST);
  assign data_data_ok = pop && (fifo_head == REQ_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign err          = err_q;

  arb_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
    .clk    (clk),
    .rst_n  (resetn),
    .push_i (accept),
    .id_i   (sel_data ? REQ_DATA : REQ_INST),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(outstanding),
    .head_o (fifo_head)
  );

  always_comb begin
    starve_d = starve_q;
    if (!inst_req || inst_addr_ok)           starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))    starve_d = starve_q + SW'(1);
    // A response with nothing in flight is a slave protocol violation.
    err_d = err_q || (bus_data_ok && fifo_empty);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: inputs change on the falling edge,
// outputs are compared 1ns later against hand-computed values.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic [1:0]  data_size;
  logic        bus_addr_ok, bus_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic        bus_req, bus_wr, err;
  logic [1:0]  bus_size;
  logic [2:0]  outstanding;

  int nvec = 0;
  int nerr = 0;

  sram_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; data_wr = 0; data_size = 2'd2;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    int acc;
    resetn = 0;
    idle();
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busreq", 32'(bus_req), 0);
    chk("rst_iaok", 32'(inst_addr_ok), 0);
    chk("rst_ddok", 32'(data_data_ok), 0);

    // Single fetch: addr_ok cycle 0, data_ok cycle 2
    inst_req = 1; inst_addr = 32'hBFC0_0000; bus_addr_ok = 1;
    #1;
    chk("t1_iaok", 32'(inst_addr_ok), 1);
    chk("t1_addr", bus_addr, 32'hBFC0_0000);
    chk("t1_size", 32'(bus_size), 2);
    chk("t1_wr", 32'(bus_wr), 0);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0;
    #1;
    chk("t1_out1", 32'(outstanding), 1);
    chk("t1_idok_c1", 32'(inst_data_ok), 0);
    @(negedge clk);
    bus_data_ok = 1; bus_rdata = 32'h3C08_0001;
    #1;
    chk("t1_idok", 32'(inst_data_ok), 1);
    chk("t1_irdata", inst_rdata, 32'h3C08_0001);
    chk("t1_ddok", 32'(data_data_ok), 0);
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    chk("t1_out0", 32'(outstanding), 0);

    // Both request: data first, then inst; responses D then I
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_addr = 32'h8000_1000; data_wr = 0; data_size = 2'd2;
    bus_addr_ok = 1;
    #1;
    chk("t2_daok", 32'(data_addr_ok), 1);
    chk("t2_iaok0", 32'(inst_addr_ok), 0);
    chk("t2_addr", bus_addr, 32'h8000_1000);
    @(negedge clk);
    data_req = 0;
    #1;
    chk("t2_iaok1", 32'(inst_addr_ok), 1);
    chk("t2_iaddr", bus_addr, 32'hBFC0_0004);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
    #1;
    chk("t2_r1_d", 32'(data_data_ok), 1);
    chk("t2_r1_i", 32'(inst_data_ok), 0);
    chk("t2_drdata", data_rdata, 32'h1111_2222);
    @(negedge clk);
    bus_rdata = 32'h3333_4444;
    #1;
    chk("t2_r2_i", 32'(inst_data_ok), 1);
    chk("t2_r2_d", 32'(data_data_ok), 0);
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    chk("t2_out0", 32'(outstanding), 0);
    chk("t2_err", 32'(err), 0);

    // Fill: slave never answers
    @(negedge clk);
    do_reset();
    inst_req = 1; data_req = 1; bus_addr_ok = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (inst_addr_ok || data_addr_ok) acc++;
      @(negedge clk);
    end
    #1;
    chk("t3_acc", 32'(acc), 4);
    chk("t3_busreq", 32'(bus_req), 0);
    chk("t3_out4", 32'(outstanding), 4);
    bus_data_ok = 1;
    #1;
    chk("t3_pop_d", 32'(data_data_ok), 1);
    chk("t3_busreq_full", 32'(bus_req), 0);
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    chk("t3_out3", 32'(outstanding), 3);
    chk("t3_reacc", 32'(inst_addr_ok || data_addr_ok), 1);
    @(negedge clk);
    #1;
    chk("t3_out4b", 32'(outstanding), 4);

    // Starvation: inst loses 7 cycles, wins the 8th, then loses again
    @(negedge clk);
    do_reset();
    inst_req = 1; data_req = 1; bus_addr_ok = 1;
    for (int k = 0; k < 10; k++) begin
      bus_data_ok = (k != 0);
      #1;
      chk($sformatf("t4_daok%0d", k), 32'(data_addr_ok), 32'(k != 7));
      chk($sformatf("t4_iaok%0d", k), 32'(inst_addr_ok), 32'(k == 7));
      @(negedge clk);
    end
    idle();
    #1;
    chk("t4_err", 32'(err), 0);

    // Stray response with empty FIFO
    @(negedge clk);
    do_reset();
    bus_data_ok = 1;
    #1;
    chk("t5_idok", 32'(inst_data_ok), 0);
    chk("t5_ddok", 32'(data_data_ok), 0);
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    chk("t5_err1", 32'(err), 1);
    chk("t5_out", 32'(outstanding), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_sticky", 32'(err), 1);
    do_reset();
    #1;
    chk("t5_clr", 32'(err), 0);

    // Async reset mid-operation with 3 outstanding
    inst_req = 1; inst_addr = 32'hBFC0_0010; bus_addr_ok = 1;
    repeat (3) @(negedge clk);
    bus_addr_ok = 0;
    #1;
    chk("t6_out3", 32'(outstanding), 3);
    chk("t6_busreq1", 32'(bus_req), 1);
    #1;
    resetn = 0;
    #1;
    chk("t6_out_rst", 32'(outstanding), 0);
    chk("t6_busreq_rst", 32'(bus_req), 0);
    @(negedge clk);
    resetn = 1; bus_addr_ok = 1; inst_addr = 32'hBFC0_0020;
    #1;
    chk("t6_iaok", 32'(inst_addr_ok), 1);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0;
    #1;
    chk("t6_out1", 32'(outstanding), 1);
    @(negedge clk);
    bus_data_ok = 1; bus_rdata = 32'hCAFE_0001;
    #1;
    chk("t6_idok", 32'(inst_data_ok), 1);
    chk("t6_ddok", 32'(data_data_ok), 0);
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    chk("t6_out0", 32'(outstanding), 0);
    chk("t6_err", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
